// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake plus serial/status outputs of uart_tx_frame.
// DATA_BITS must match the DATA_BITS of the transmitter it is attached to.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] DIN;
  logic                 VALID;
  logic                 READY;
  logic                 BUSY;
  logic                 DONE;
  logic                 TXD;

  modport master (
    output DIN,
    output VALID,
    input  READY,
    input  BUSY,
    input  DONE,
    input  TXD
  );

  modport slave (
    input  DIN,
    input  VALID,
    output READY,
    output BUSY,
    output DONE,
    output TXD
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: START, DATA (LSB first), optional PARITY, STOP_BITS stop bits.
// Define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry input buffer for back-to-back frames.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_frame_if.slave bus
);

`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (FIFO_EN && (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of 2, at least 2");
  end

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;

  logic                 bit_end;
  logic                 last_stop;
  logic                 done_cycle;
  logic                 frame_free;
  logic                 load;
  logic [DATA_BITS-1:0] load_word;
  logic                 line_bit;

  assign bit_end    = (baud_q == BAUD_LAST);
  assign last_stop  = (STOP_BITS == 1) || stop_q;
  assign done_cycle = (state_q == S_STOP) && bit_end && last_stop;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 ready_q;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 store;

  // The final stop cycle counts as free so the next start bit follows with no gap.
  assign frame_free = (state_q == S_IDLE) || done_cycle;
  assign fifo_empty = (count_q == '0);
  assign push       = bus.VALID & bus.READY;
  assign pop        = frame_free & ~fifo_empty;
  // An empty FIFO with a free FSM is bypassed to keep the 1-cycle accept latency.
  assign store      = push & ~(frame_free & fifo_empty);
  assign load       = frame_free & (~fifo_empty | push);
  assign load_word  = fifo_empty ? bus.DIN : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = store ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (store && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!store && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (store) begin
      mem[wr_ptr_q] <= bus.DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= (count_d != CNT_FULL);
    end
  end

  assign bus.READY = ready_q & ~RST;
  assign bus.BUSY  = ((state_q != S_IDLE) | ~fifo_empty) & ~RST;
`else
  assign frame_free = (state_q == S_IDLE);
  assign load       = frame_free & bus.VALID;
  assign load_word  = bus.DIN;
  assign bus.READY  = (state_q == S_IDLE) & ~RST;
  assign bus.BUSY   = (state_q != S_IDLE) & ~RST;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + BAUD_ONE;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A new word overrides the return to IDLE, so it can start right after DONE.
    if (load) begin
      state_d = S_START;
      baud_d  = '0;
      shift_d = load_word;
      par_d   = (PARITY == 1) ? ~(^load_word) : ^load_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    line_bit = 1'b1;
    case (state_q)
      S_START:  line_bit = 1'b0;
      S_DATA:   line_bit = shift_q[0];
      S_PARITY: line_bit = par_q;
      default:  line_bit = 1'b1;
    endcase
  end

  assign bus.TXD  = line_bit | RST;
  assign bus.DONE = done_cycle & ~RST;

endmodule
